// File: rtl/flash_boot_copier_pkg.sv
// Shared constants for the flash boot copier: FSM encodings, flash register
// offsets and the tail-word byte-select helper.
package flash_boot_copier_pkg;

  // Copier FSM states
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSetAdr = 3'd1;
  localparam logic [2:0] StRdByte = 3'd2;
  localparam logic [2:0] StWrWord = 3'd3;
  localparam logic [2:0] StFinish = 3'd4;

  // Single-transaction bus master states
  localparam logic [1:0] MsIdle  = 2'd0;
  localparam logic [1:0] MsIssue = 2'd1;
  localparam logic [1:0] MsWait  = 2'd2;

  // Flash slave register offsets (bit 0 of the bus address)
  localparam logic [31:0] FLASH_ADR_OFS = 32'd1;
  localparam logic [31:0] FLASH_DAT_OFS = 32'd0;

  // Byte selects for a word holding rem valid low bytes; rem==0 means full word.
  function automatic logic [3:0] tail_sel(input logic [1:0] rem);
    logic [3:0] sel;
    case (rem)
      2'd1:    sel = 4'h1;
      2'd2:    sel = 4'h3;
      2'd3:    sel = 4'h7;
      default: sel = 4'hF;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/flash_boot_copier_if.sv
// Pipelined Wishbone master/slave signal bundle used by the flash boot copier.
interface flash_boot_copier_if;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        we_o;
  logic [3:0]  sel_o;
  logic        cyc_o;
  logic        stb_o;
  logic        ack_i;
  logic        err_i;
  logic        rty_i;
  logic        stall_i;

  modport master (
    output adr_o, dat_o, we_o, sel_o, cyc_o, stb_o,
    input  dat_i, ack_i, err_i, rty_i, stall_i
  );

  modport slave (
    input  adr_o, dat_o, we_o, sel_o, cyc_o, stb_o,
    output dat_i, ack_i, err_i, rty_i, stall_i
  );
endinterface

// File: rtl/flash_boot_copier_wb_single_master.sv
// Issues one pipelined Wishbone transaction per req pulse and reports the outcome.
// Issue phase holds the request until a non-stalled cycle, wait phase keeps cyc
// up until ack/err/rty. Either phase gives up after TIMEOUT cycles.
module wb_single_master
  import flash_boot_copier_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic [31:0]         req_adr,
  input  logic [31:0]         req_dat,
  input  logic                req_we,
  input  logic [3:0]          req_sel,
  output logic                rsp_done,
  output logic                rsp_fail,
  output logic [31:0]         rsp_dat,
  flash_boot_copier_if.master bus
);

  localparam int unsigned    CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [1:0]      st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     adr_q, adr_d, dat_q, dat_d, rdat_q, rdat_d;
  logic            done_q, done_d, fail_q, fail_d;
  logic            resp, expired;

  // rty is folded into failure alongside err
  assign resp    = bus.ack_i | bus.err_i | bus.rty_i;
  assign expired = (cnt_q == CntLast);

  // Transaction sequencing: launch, stall handling, response/timeout
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    cyc_d  = cyc_q;
    stb_d  = stb_q;
    we_d   = we_q;
    sel_d  = sel_q;
    adr_d  = adr_q;
    dat_d  = dat_q;
    rdat_d = rdat_q;
    done_d = 1'b0;
    fail_d = 1'b0;
    unique case (st_q)
      MsIdle: begin
        if (req) begin
          st_d  = MsIssue;
          cyc_d = 1'b1;
          stb_d = 1'b1;
          we_d  = req_we;
          sel_d = req_sel;
          adr_d = req_adr;
          dat_d = req_dat;
          cnt_d = '0;
        end
      end
      MsIssue: begin
        if (!bus.stall_i) begin
          st_d  = MsWait;
          stb_d = 1'b0;
          cnt_d = '0;
        end else if (expired) begin
          st_d   = MsIdle;
          cyc_d  = 1'b0;
          stb_d  = 1'b0;
          done_d = 1'b1;
          fail_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MsWait: begin
        if (resp) begin
          st_d   = MsIdle;
          cyc_d  = 1'b0;
          done_d = 1'b1;
          fail_d = bus.err_i | bus.rty_i;
          rdat_d = bus.dat_i;
        end else if (expired) begin
          st_d   = MsIdle;
          cyc_d  = 1'b0;
          done_d = 1'b1;
          fail_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        st_d  = MsIdle;
        cyc_d = 1'b0;
        stb_d = 1'b0;
      end
    endcase
  end

  // State and registered bus outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= MsIdle;
      cnt_q  <= '0;
      cyc_q  <= 1'b0;
      stb_q  <= 1'b0;
      we_q   <= 1'b0;
      sel_q  <= '0;
      adr_q  <= '0;
      dat_q  <= '0;
      rdat_q <= '0;
      done_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      cyc_q  <= cyc_d;
      stb_q  <= stb_d;
      we_q   <= we_d;
      sel_q  <= sel_d;
      adr_q  <= adr_d;
      dat_q  <= dat_d;
      rdat_q <= rdat_d;
      done_q <= done_d;
      fail_q <= fail_d;
    end
  end

  assign bus.cyc_o = cyc_q;
  assign bus.stb_o = stb_q;
  assign bus.we_o  = we_q;
  assign bus.sel_o = sel_q;
  assign bus.adr_o = adr_q;
  assign bus.dat_o = dat_q;
  assign rsp_done  = done_q;
  assign rsp_fail  = fail_q;
  assign rsp_dat   = rdat_q;

endmodule

// File: rtl/flash_boot_copier.sv
// Copies a byte range out of the byte-wide flash slave into memory, packing four
// bytes little-endian per 32-bit write. The flash address register is rewritten
// before every byte read because the slave does not auto-increment.
module flash_boot_copier
  import flash_boot_copier_pkg::*;
#(
  parameter logic [31:0] FLASH_BASE = 32'h0100_0000,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                clk_bus,
  input  logic                rst_bus,
  input  logic                start_i,
  input  logic [22:0]         src_i,
  input  logic [31:0]         dst_i,
  input  logic [15:0]         len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                fail_o,
  flash_boot_copier_if.master bus
);

  logic [2:0]  state_q, state_d;
  logic [22:0] src_q, src_d;
  logic [31:0] wadr_q, wadr_d;
  logic [15:0] len_q, len_d;
  logic [15:0] k_q, k_d, k_inc;
  logic [31:0] buf_q, buf_d;
  logic        busy_q, busy_d, done_q, done_d, fail_q, fail_d, req_q, req_d;

  logic [31:0] req_adr, req_dat;
  logic        req_we;
  logic [3:0]  req_sel;
  logic        rsp_done, rsp_fail, rsp_ok;
  logic [31:0] rsp_dat;
  logic        unused_rsp;

  assign k_inc      = k_q + 16'd1;
  assign rsp_ok     = rsp_done & ~rsp_fail;
  assign unused_rsp = ^rsp_dat[31:8];

  // Request fields follow the current state; the master latches them on req
  always_comb begin
    req_adr = '0;
    req_dat = '0;
    req_we  = 1'b0;
    req_sel = '0;
    case (state_q)
      StSetAdr: begin
        req_adr = FLASH_BASE | FLASH_ADR_OFS;
        req_dat = {9'b0, src_q + 23'(k_q)};
        req_we  = 1'b1;
        req_sel = 4'hF;
      end
      StRdByte: begin
        req_adr = FLASH_BASE | FLASH_DAT_OFS;
        req_sel = 4'h1;
      end
      StWrWord: begin
        req_adr = wadr_q;
        req_dat = buf_q;
        req_we  = 1'b1;
        // k[1:0]==0 here means a full word, otherwise the tail
        req_sel = tail_sel(k_q[1:0]);
      end
      default: ;
    endcase
  end

  // Copier FSM, byte counter and packing buffer
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    wadr_d  = wadr_q;
    len_d   = len_q;
    k_d     = k_q;
    buf_d   = buf_q;
    busy_d  = busy_q;
    fail_d  = fail_q;
    done_d  = 1'b0;
    req_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          src_d  = src_i;
          wadr_d = {dst_i[31:2], 2'b00};
          len_d  = len_i;
          k_d    = '0;
          buf_d  = '0;
          busy_d = 1'b1;
          fail_d = 1'b0;
          if (len_i == 16'd0) begin
            state_d = StFinish;
          end else begin
            state_d = StSetAdr;
            req_d   = 1'b1;
          end
        end
      end
      StSetAdr: begin
        if (rsp_ok) begin
          state_d = StRdByte;
          req_d   = 1'b1;
        end
      end
      StRdByte: begin
        if (rsp_ok) begin
          buf_d   = buf_q | ({24'b0, rsp_dat[7:0]} << {k_q[1:0], 3'b000});
          k_d     = k_inc;
          req_d   = 1'b1;
          state_d = (k_inc[1:0] == 2'd0 || k_inc == len_q) ? StWrWord : StSetAdr;
        end
      end
      StWrWord: begin
        if (rsp_ok) begin
          buf_d  = '0;
          wadr_d = wadr_q + 32'd4;
          if (k_q == len_q) begin
            state_d = StFinish;
          end else begin
            state_d = StSetAdr;
            req_d   = 1'b1;
          end
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A failed transaction abandons the copy; the partial buffer is never written
    if (rsp_done && rsp_fail) begin
      state_d = StFinish;
      fail_d  = 1'b1;
      buf_d   = '0;
      req_d   = 1'b0;
    end
  end

  // Copier state registers
  always_ff @(posedge clk_bus or negedge rst_bus) begin
    if (!rst_bus) begin
      state_q <= StIdle;
      src_q   <= '0;
      wadr_q  <= '0;
      len_q   <= '0;
      k_q     <= '0;
      buf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      wadr_q  <= wadr_d;
      len_q   <= len_d;
      k_q     <= k_d;
      buf_q   <= buf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      req_q   <= req_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign fail_o = fail_q;

  wb_single_master #(
    .TIMEOUT (TIMEOUT)
  ) u_master (
    .clk      (clk_bus),
    .rst_n    (rst_bus),
    .req      (req_q),
    .req_adr  (req_adr),
    .req_dat  (req_dat),
    .req_we   (req_we),
    .req_sel  (req_sel),
    .rsp_done (rsp_done),
    .rsp_fail (rsp_fail),
    .rsp_dat  (rsp_dat),
    .bus      (bus)
  );

endmodule
